// File: rtl/top_in_pkg.sv
// Shared constants, outer FSM state type and byte selection helper
// for the 64-bit word UART transmitter.
package top_in_pkg;

    localparam int CLK_FREQ_DEF = 50_000_000;
    localparam int BAUD_DEF     = 115_200;
    localparam int BAUD_DIV_DEF = CLK_FREQ_DEF / BAUD_DEF;
    localparam int NUM_BYTES    = 8;
    localparam int FRAME_LEN    = 10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND,
        ST_NEXT
    } state_t;

    // Byte 0 is the most significant byte of the word.
    function automatic logic [7:0] byte_of(
        input logic [63:0] w,
        input logic [2:0]  idx
    );
        return w[{~idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/top_in_uart_byte_tx.sv
// Single 8N1 frame transmitter: 10-bit shift register plus baud counter.
// tx_done pulses for one clock at the end of the stop bit.
module uart_byte_tx
    import top_in_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       txd,
    output logic       tx_done,
    output logic       tx_busy
);

    localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int BW = $clog2(FRAME_LEN);

    logic [FRAME_LEN-1:0] shreg;
    logic [CW-1:0]        baud_cnt;
    logic [BW-1:0]        bit_cnt;
    logic                 bit_end;
    logic                 last_bit;

    assign bit_end  = (baud_cnt == CW'(BAUD_DIV - 1));
    assign last_bit = (bit_cnt == BW'(FRAME_LEN - 1));

    always_ff @(posedge clk) begin
        if (rst_n) begin
            shreg    <= '1;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            tx_busy  <= 1'b0;
            tx_done  <= 1'b0;
            txd      <= 1'b1;
        end else begin
            tx_done <= 1'b0;
            // Line output is a registered copy of the shift register LSB.
            txd     <= tx_busy ? shreg[0] : 1'b1;
            if (!tx_busy) begin
                if (tx_start) begin
                    shreg    <= {1'b1, tx_data, 1'b0};
                    baud_cnt <= '0;
                    bit_cnt  <= '0;
                    tx_busy  <= 1'b1;
                end
            end else if (bit_end) begin
                baud_cnt <= '0;
                shreg    <= {1'b1, shreg[FRAME_LEN-1:1]};
                if (last_bit) begin
                    tx_busy <= 1'b0;
                    tx_done <= 1'b1;
                    bit_cnt <= '0;
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end else begin
                baud_cnt <= baud_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/top_in_uart.sv
// Sends a captured 64-bit word as eight 8N1 frames, MSB byte first,
// launched by a rising edge on manual_start.
module top_in_uart
    import top_in_pkg::*;
#(
    parameter int CLK_FREQ = CLK_FREQ_DEF,
    parameter int BAUD     = BAUD_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] data_64,
    input  logic        manual_start,
    output logic        uart_txd
);

    localparam int BAUD_DIV = CLK_FREQ / BAUD;

    state_t      state;
    state_t      state_nx;
    logic [2:0]  idx;
    logic [2:0]  idx_nx;
    logic [2:0]  sel;
    logic [63:0] word_q;
    logic [7:0]  tx_data;
    logic        start_d;
    logic        start_evt;
    logic        accept;
    logic        busy;
    logic        tx_start;
    logic        tx_done;
    logic        tx_busy;

    assign start_evt = manual_start & ~start_d;
    assign busy      = (state != ST_IDLE) | tx_busy;
    assign accept    = start_evt & ~busy;
    assign tx_data   = byte_of(word_q, sel);

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state   <= ST_IDLE;
            idx     <= '0;
            start_d <= 1'b0;
            word_q  <= '0;
        end else begin
            state   <= state_nx;
            idx     <= idx_nx;
            start_d <= manual_start;
            if (accept) begin
                word_q <= data_64;
            end
        end
    end

    // NEXT presents the following byte in the same cycle it pulses tx_start.
    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        sel      = idx;
        tx_start = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nx = ST_LOAD;
                end
            end
            ST_LOAD: begin
                idx_nx   = '0;
                sel      = '0;
                tx_start = 1'b1;
                state_nx = ST_SEND;
            end
            ST_SEND: begin
                if (tx_done) begin
                    state_nx = ST_NEXT;
                end
            end
            ST_NEXT: begin
                if (idx == 3'(NUM_BYTES - 1)) begin
                    state_nx = ST_IDLE;
                end else begin
                    idx_nx   = idx + 3'd1;
                    sel      = idx + 3'd1;
                    tx_start = 1'b1;
                    state_nx = ST_SEND;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    uart_byte_tx #(
        .BAUD_DIV(BAUD_DIV)
    ) u_byte_tx (
        .clk     (clk),
        .rst_n   (rst_n),
        .tx_start(tx_start),
        .tx_data (tx_data),
        .txd     (uart_txd),
        .tx_done (tx_done),
        .tx_busy (tx_busy)
    );

endmodule

// File: tb/tb_top_in_uart.sv
// Bench for top_in_uart: line decoder plus a word-level expectation queue,
// run with a short bit time to keep simulation small.
module tb_top_in_uart;

    localparam int CLK_FREQ = 1_000_000;
    localparam int BAUD     = 62_500;
    localparam int D        = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        manual_start = 1'b0;
    logic [63:0] data_64 = '0;
    logic        uart_txd;

    top_in_uart #(
        .CLK_FREQ(CLK_FREQ),
        .BAUD    (BAUD)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .data_64     (data_64),
        .manual_start(manual_start),
        .uart_txd    (uart_txd)
    );

    always #10 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Word-level model: accepted start edges queue the eight bytes.
    logic [7:0] exp_q[$];
    int pcnt = 0;
    int t_evt = 0;
    int word_pos = 0;
    logic m_prev = 1'b0;

    initial forever begin
        @(posedge clk);
        pcnt++;
        if (rst_n) begin
            m_prev = 1'b0;
            exp_q.delete();
            word_pos = 0;
        end else begin
            if (manual_start && !m_prev && exp_q.size() == 0) begin
                for (int i = 0; i < 8; i++)
                    exp_q.push_back(data_64[63-8*i -: 8]);
                t_evt = pcnt;
                word_pos = 0;
            end
            m_prev = manual_start;
        end
    end

    // Line decoder: frame boundaries, bit hold times, latency and gaps.
    int frames = 0;
    logic in_frame = 1'b0;
    int cyc = 0;
    int fs = 0;
    int prev_fs = 0;
    int hold_err = 0;
    logic [9:0] bits = '0;

    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            in_frame = 1'b0;
        end else if (!in_frame) begin
            if (uart_txd == 1'b0) begin
                in_frame = 1'b1;
                cyc = 1;
                bits = '0;
                fs = pcnt;
                hold_err = 0;
                if (word_pos == 0)
                    check("latency", 64'(fs - t_evt), 64'd2);
                else
                    check("gap_le2", 64'((fs - prev_fs - 10*D) <= 2), 64'd1);
            end
        end else begin
            if (cyc % D == 0)
                bits[cyc/D] = uart_txd;
            else if (uart_txd !== bits[cyc/D])
                hold_err++;
            cyc++;
            if (cyc == 10*D) begin
                frames++;
                if (exp_q.size() == 0)
                    check("spurious_frame", 64'(exp_q.size()), 64'd1);
                else
                    check("byte", 64'(bits[8:1]), 64'(exp_q.pop_front()));
                check("stop_bit", 64'(bits[9]), 64'd1);
                check("bit_hold", 64'(hold_err), 64'd0);
                if (frames == 1)
                    check("frame0_bits", 64'(bits), 64'(10'b1001011000));
                if (word_pos == 7)
                    check("word_dur",
                          64'((fs + 10*D - t_evt) <= 80*D + 16), 64'd1);
                prev_fs = fs;
                word_pos++;
                in_frame = 1'b0;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input int w);
        manual_start = 1'b1;
        tick(w);
        manual_start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int lim);
        int n = 0;
        tick(4);
        while ((exp_q.size() != 0 || in_frame) && n < lim) begin
            tick(1);
            n++;
        end
        check(tag, 64'(n < lim), 64'd1);
        tick(20);
    endtask

    int f0;

    initial begin
        tick(5);
        check("rst_txd", 64'(uart_txd), 64'd1);
        rst_n = 1'b0;
        tick(300);
        check("idle_txd", 64'(uart_txd), 64'd1);
        check("idle_frames", 64'(frames), 64'd0);

        // Known word, 2-clock start, data changed without a start edge.
        data_64 = 64'h2CFF_0AEF_8AE1_6865;
        pulse(2);
        tick(10*D);
        data_64 = 64'hE429_F657_A7C2_DB78;
        wait_done("word1_tmo", 100*D);
        tick(3*D);
        check("word1_frames", 64'(frames), 64'd8);
        check("word1_idle", 64'(uart_txd), 64'd1);

        // Start edge during byte 3 is ignored.
        data_64 = {$urandom, $urandom};
        pulse(1);
        tick(30*D + D/2);
        data_64 = 64'hE429_F657_A7C2_DB78;
        pulse(3);
        wait_done("word2_tmo", 100*D);
        check("ignored_start", 64'(frames), 64'd16);
        pulse(1);
        wait_done("word3_tmo", 100*D);
        check("word3_frames", 64'(frames), 64'd24);

        // Long start level yields one transfer.
        data_64 = {$urandom, $urandom};
        manual_start = 1'b1;
        tick(2*80*D + 40);
        manual_start = 1'b0;
        wait_done("long_tmo", 100*D);
        check("long_frames", 64'(frames), 64'd32);

        // Random words, pulse widths and mid-transfer data churn.
        for (int i = 0; i < 4; i++) begin
            data_64 = {$urandom, $urandom};
            pulse(int'($urandom_range(1, 6)));
            tick(int'($urandom_range(0, 60*D)));
            data_64 = {$urandom, $urandom};
            wait_done("rand_tmo", 100*D);
            check("rand_frames", 64'(frames), 64'(40 + 8*i));
        end

        // Reset in the middle of byte 2's start bit.
        data_64 = {$urandom, $urandom};
        pulse(1);
        tick(20*D + 12 - 1);
        check("pre_rst_low", 64'(uart_txd), 64'd0);
        rst_n = 1'b1;
        tick(1);
        check("rst_abort_txd", 64'(uart_txd), 64'd1);
        tick(3);
        rst_n = 1'b0;
        f0 = frames;
        tick(2*80*D);
        check("post_rst_frames", 64'(frames), 64'(f0));
        check("post_rst_txd", 64'(uart_txd), 64'd1);
        data_64 = {$urandom, $urandom};
        pulse(2);
        wait_done("final_tmo", 100*D);
        check("final_frames", 64'(frames), 64'(f0 + 8));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
